// File: rtl/commit_store_buffer_if.sv
// Bundles the LSU, commit-stage and D$ signals of commit_store_buffer.
// slave is the store buffer's view; master is the surrounding pipeline's view.
interface commit_store_buffer_if #(
   parameter int unsigned PLEN = 56,
   parameter int unsigned XLEN = 64
);
   logic              flush_i;
   logic              valid_i;
   logic [PLEN-1:0]   paddr_i;
   logic [XLEN-1:0]   data_i;
   logic [XLEN/8-1:0] be_i;
   logic              ready_o;
   logic              commit_i;
   logic              commit_ready_o;
   logic              no_st_pending_o;
   logic              req_valid_o;
   logic [PLEN-1:0]   req_addr_o;
   logic [XLEN-1:0]   req_data_o;
   logic [XLEN/8-1:0] req_be_o;
   logic              req_gnt_i;
   logic              resp_ack_i;
   logic [11:0]       fwd_offset_i;
   logic              fwd_match_o;

   modport slave (
      input  flush_i, valid_i, paddr_i, data_i, be_i, commit_i,
             req_gnt_i, resp_ack_i, fwd_offset_i,
      output ready_o, commit_ready_o, no_st_pending_o, req_valid_o,
             req_addr_o, req_data_o, req_be_o, fwd_match_o
   );

   modport master (
      output flush_i, valid_i, paddr_i, data_i, be_i, commit_i,
             req_gnt_i, resp_ack_i, fwd_offset_i,
      input  ready_o, commit_ready_o, no_st_pending_o, req_valid_o,
             req_addr_o, req_data_o, req_be_o, fwd_match_o
   );
endinterface

// File: rtl/commit_store_buffer.sv
// Two-level store buffer: speculative FIFO filled by the LSU, retired into a
// commit FIFO by commit_i, drained to the D$ one write at a time.
// Optional load/store overlap detection is built when STORE_BUF_FWD_EN is defined.
module commit_store_buffer #(
   parameter int unsigned SPEC_DEPTH   = 4,
   parameter int unsigned COMMIT_DEPTH = 8,
   parameter int unsigned PLEN         = 56,
   parameter int unsigned XLEN         = 64
) (
   input logic                  clk_i,
   input logic                  rst_i,
   commit_store_buffer_if.slave bus
);
   localparam int unsigned SPW = $clog2(SPEC_DEPTH);
   localparam int unsigned CMW = $clog2(COMMIT_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t state, state_nxt;

   logic [PLEN-1:0]   spec_addr [SPEC_DEPTH];
   logic [XLEN-1:0]   spec_data [SPEC_DEPTH];
   logic [XLEN/8-1:0] spec_be   [SPEC_DEPTH];
   logic [SPW-1:0]    spec_rd, spec_wr;
   logic [SPW:0]      spec_count;

   logic [PLEN-1:0]   commit_addr [COMMIT_DEPTH];
   logic [XLEN-1:0]   commit_data [COMMIT_DEPTH];
   logic [XLEN/8-1:0] commit_be   [COMMIT_DEPTH];
   logic [CMW-1:0]    commit_rd, commit_wr;
   logic [CMW:0]      commit_count;

   logic ready, commit_ready, push, commit, pop, req_valid;

   assign ready        = (spec_count != (SPW+1)'(SPEC_DEPTH));
   assign commit_ready = (commit_count != (CMW+1)'(COMMIT_DEPTH));
   assign commit       = bus.commit_i && (spec_count != '0) && commit_ready;
   assign push         = bus.valid_i && ready && !bus.flush_i;
   assign pop          = (state == WAIT) && bus.resp_ack_i;

   // Speculative queue pointers; flush drops everything behind a same-cycle commit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         spec_rd    <= '0;
         spec_wr    <= '0;
         spec_count <= '0;
      end else if (bus.flush_i) begin
         spec_rd    <= spec_wr;
         spec_count <= '0;
      end else begin
         if (push)   spec_wr <= spec_wr + SPW'(1);
         if (commit) spec_rd <= spec_rd + SPW'(1);
         spec_count <= spec_count + (SPW+1)'(push) - (SPW+1)'(commit);
      end
   end

   // Commit queue pointers; a pop and a push in one cycle leave the count as is.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         commit_rd    <= '0;
         commit_wr    <= '0;
         commit_count <= '0;
      end else begin
         if (commit) commit_wr <= commit_wr + CMW'(1);
         if (pop)    commit_rd <= commit_rd + CMW'(1);
         commit_count <= commit_count + (CMW+1)'(commit) - (CMW+1)'(pop);
      end
   end

   // Entry storage; validity is carried entirely by the pointers and counts.
   always_ff @(posedge clk_i) begin
      if (push) begin
         spec_addr[spec_wr] <= bus.paddr_i;
         spec_data[spec_wr] <= bus.data_i;
         spec_be[spec_wr]   <= bus.be_i;
      end
      if (commit) begin
         commit_addr[commit_wr] <= spec_addr[spec_rd];
         commit_data[commit_wr] <= spec_data[spec_rd];
         commit_be[commit_wr]   <= spec_be[spec_rd];
      end
   end

   // Drain FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Drain FSM next state and request strobe.
   always_comb begin
      state_nxt = state;
      req_valid = 1'b0;
      unique case (state)
         IDLE: if (commit_count != '0) state_nxt = REQ;
         REQ: begin
            req_valid = 1'b1;
            if (bus.req_gnt_i) state_nxt = WAIT;
         end
         WAIT: if (bus.resp_ack_i) state_nxt = (commit_count > (CMW+1)'(1)) ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.ready_o         = ready;
   assign bus.commit_ready_o  = commit_ready;
   assign bus.no_st_pending_o = (commit_count == '0) && (state == IDLE);
   assign bus.req_valid_o     = req_valid;
   assign bus.req_addr_o      = req_valid ? commit_addr[commit_rd] : '0;
   assign bus.req_data_o      = req_valid ? commit_data[commit_rd] : '0;
   assign bus.req_be_o        = req_valid ? commit_be[commit_rd]   : '0;

`ifdef STORE_BUF_FWD_EN
   logic fwd_match;
   logic unused_fwd_low;
   assign unused_fwd_low = ^bus.fwd_offset_i[2:0];

   // Any live entry (in-flight commit head included) sharing the load's doubleword.
   always_comb begin
      fwd_match = 1'b0;
      for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
         if (((SPW+1)'(SPW'(i) - spec_rd) < spec_count) &&
             (spec_addr[SPW'(i)][11:3] == bus.fwd_offset_i[11:3]) &&
             (spec_be[SPW'(i)] != '0))
            fwd_match = 1'b1;
      end
      for (int unsigned i = 0; i < COMMIT_DEPTH; i++) begin
         if (((CMW+1)'(CMW'(i) - commit_rd) < commit_count) &&
             (commit_addr[CMW'(i)][11:3] == bus.fwd_offset_i[11:3]) &&
             (commit_be[CMW'(i)] != '0))
            fwd_match = 1'b1;
      end
   end
   assign bus.fwd_match_o = fwd_match;
`else
   logic unused_fwd;
   assign unused_fwd      = ^bus.fwd_offset_i;
   assign bus.fwd_match_o = 1'b0;
`endif

   commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.commit_i |-> ((spec_count != '0) && commit_ready));

endmodule

// File: tb/tb_commit_store_buffer.sv
// Scoreboard bench for commit_store_buffer: directed scenarios plus random
// traffic checked against a queue-based model of the two store queues.
module tb_commit_store_buffer;
   localparam int unsigned SD = 4;
   localparam int unsigned CD = 8;

   typedef struct packed {
      logic [55:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   commit_store_buffer_if #(.PLEN(56), .XLEN(64)) bus ();

   commit_store_buffer #(
      .SPEC_DEPTH(SD), .COMMIT_DEPTH(CD), .PLEN(56), .XLEN(64)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   st_t spec_q[$];   // stores waiting for commit
   st_t cq[$];       // committed, not yet acknowledged
   st_t exp_q[$];    // committed, not yet granted: expected D$ request order

   bit auto_resp = 1'b0;
   int gnt_pct = 100;
   int ack_pct = 100;
   bit man_gnt = 1'b0;
   bit man_ack = 1'b0;
   bit ack_real = 1'b0;
   int rphase = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit fwd_exp(input logic [11:0] off);
      bit m = 1'b0;
`ifdef STORE_BUF_FWD_EN
      st_t e;
      foreach (spec_q[i]) begin
         e = spec_q[i];
         if (e.addr[11:3] == off[11:3] && e.be != 8'h00) m = 1'b1;
      end
      foreach (cq[i]) begin
         e = cq[i];
         if (e.addr[11:3] == off[11:3] && e.be != 8'h00) m = 1'b1;
      end
`endif
      return m;
   endfunction

   // Reference model: apply each edge's inputs to the queues.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         spec_q.delete();
         cq.delete();
         exp_q.delete();
      end else begin
         bit c, p;
         st_t e;
         c = bus.commit_i && (spec_q.size() != 0) && (cq.size() != CD);
         p = bus.valid_i && (spec_q.size() != SD) && !bus.flush_i;
         if (bus.resp_ack_i && ack_real) void'(cq.pop_front());
         if (c) begin
            e = spec_q.pop_front();
            cq.push_back(e);
            exp_q.push_back(e);
         end
         if (bus.flush_i) spec_q.delete();
         else if (p) spec_q.push_back('{bus.paddr_i, bus.data_i, bus.be_i});
      end
   end

   // D$ responder: random gnt/ack, occasional stray ack, or manual control.
   always begin
      @(posedge clk);
      #2;
      if (rst) begin
         rphase = 0; bus.req_gnt_i = 1'b0; bus.resp_ack_i = 1'b0; ack_real = 1'b0;
      end else if (!auto_resp) begin
         bus.req_gnt_i = man_gnt; bus.resp_ack_i = man_ack; ack_real = man_ack;
      end else begin
         bus.req_gnt_i = 1'b0; bus.resp_ack_i = 1'b0; ack_real = 1'b0;
         if (rphase == 0) begin
            if (bus.req_valid_o && $urandom_range(99) < gnt_pct) begin
               bus.req_gnt_i = 1'b1; rphase = 1;
            end else if ($urandom_range(99) < 5) begin
               bus.resp_ack_i = 1'b1;
            end
         end else if ($urandom_range(99) < ack_pct) begin
            bus.resp_ack_i = 1'b1; ack_real = 1'b1; rphase = 0;
         end
      end
   end

   // Monitor: status outputs every cycle, request stability, scoreboard on grant.
   bit   stall_seen = 1'b0;
   st_t  stall_req;
   always @(negedge clk) begin
      if (rst) begin
         stall_seen = 1'b0;
      end else begin
         check("ready", bus.ready_o, spec_q.size() != SD);
         check("commit_ready", bus.commit_ready_o, cq.size() != CD);
         check("no_st_pending", bus.no_st_pending_o, cq.size() == 0);
         check("fwd_match", bus.fwd_match_o, fwd_exp(bus.fwd_offset_i));
         if (cq.size() == 0) check("req_valid_idle", bus.req_valid_o, 0);
         if (stall_seen) begin
            check("stall_valid", bus.req_valid_o, 1);
            check("stall_addr", bus.req_addr_o, stall_req.addr);
            check("stall_data", bus.req_data_o, stall_req.data);
            check("stall_be", bus.req_be_o, stall_req.be);
         end
         stall_seen = 1'b0;
         if (bus.req_valid_o) begin
            if (bus.req_gnt_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL req_unexpected: got addr %0h, expected no request at t=%0t",
                           bus.req_addr_o, $time);
               end else begin
                  st_t e;
                  e = exp_q.pop_front();
                  check("req_addr", bus.req_addr_o, e.addr);
                  check("req_data", bus.req_data_o, e.data);
                  check("req_be", bus.req_be_o, e.be);
               end
            end else begin
               stall_seen = 1'b1;
               stall_req  = '{bus.req_addr_o, bus.req_data_o, bus.req_be_o};
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [55:0] a, input logic [63:0] d,
                        input logic [7:0] b, input bit c, input bit f);
      bus.valid_i = v; bus.paddr_i = a; bus.data_i = d; bus.be_i = b;
      bus.commit_i = c; bus.flush_i = f;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0; bus.commit_i = 1'b0; bus.flush_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int budget, input string name);
      int k = 0;
      while ((spec_q.size() != 0 || cq.size() != 0) && k < budget) begin
         drive(1'b0, '0, '0, '0, (spec_q.size() != 0) && (cq.size() != CD), 1'b0);
         k++;
      end
      check(name, cq.size() + spec_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, bus.req_valid_o, 0);
      check({tag, "_req_addr"}, bus.req_addr_o, 0);
      check({tag, "_req_data"}, bus.req_data_o, 0);
      check({tag, "_req_be"}, bus.req_be_o, 0);
      check({tag, "_ready"}, bus.ready_o, 1);
      check({tag, "_commit_ready"}, bus.commit_ready_o, 1);
      check({tag, "_no_st_pending"}, bus.no_st_pending_o, 1);
      check({tag, "_fwd_match"}, bus.fwd_match_o, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [55:0] a;
      logic [55:0] held_addr;
      bit fwd_on;
      int k;
`ifdef STORE_BUF_FWD_EN
      fwd_on = 1'b1;
`else
      fwd_on = 1'b0;
`endif
      bus.valid_i = 0; bus.paddr_i = '0; bus.data_i = '0; bus.be_i = '0;
      bus.commit_i = 0; bus.flush_i = 0; bus.fwd_offset_i = '0;
      bus.req_gnt_i = 0; bus.resp_ack_i = 0;

      // Reset, then idle.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset");
      idle(10);
      check("idle_req_valid", bus.req_valid_o, 0);

      // Fill the speculative queue, refuse a fifth, commit all four in order.
      auto_resp = 1'b1; gnt_pct = 100; ack_pct = 100;
      for (int i = 0; i < 4; i++)
         drive(1'b1, 56'h1000 + 56'(i * 8), 64'hA0 + 64'(i), 8'hFF, 1'b0, 1'b0);
      check("full_ready", bus.ready_o, 0);
      drive(1'b1, 56'h1020, 64'hDEAD, 8'hFF, 1'b0, 1'b0);
      check("refused_ready", bus.ready_o, 0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      drain(60, "drain_four");
      check("four_no_st_pending", bus.no_st_pending_o, 1);

      // Commit and flush together: only the head survives.
      for (int i = 0; i < 3; i++)
         drive(1'b1, 56'h4000 + 56'(i * 8), 64'hB0 + 64'(i), 8'h0F, 1'b0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
      check("flush_ready", bus.ready_o, 1);
      drain(30, "drain_flush");
      check("flush_exp_empty", exp_q.size(), 0);

      // Stalled grant keeps the request stable; reset in WAIT abandons it.
      auto_resp = 1'b0; man_gnt = 0; man_ack = 0;
      drive(1'b1, 56'h5000, 64'h1234_5678_9ABC_DEF0, 8'h3C, 1'b0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      k = 0;
      while (!bus.req_valid_o && k < 10) begin idle(1); k++; end
      check("stall_reached_req", bus.req_valid_o, 1);
      held_addr = bus.req_addr_o;
      idle(5);
      check("stall_hold_addr", bus.req_addr_o, held_addr);
      man_gnt = 1; idle(1); man_gnt = 0;
      idle(1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midwait");
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Fill the commit queue with the grant held low.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++)
            drive(1'b1, 56'h6000 + 56'((r * 4 + i) * 8), 64'hC0 + 64'(r * 4 + i),
                  8'(i + 1), 1'b0, 1'b0);
         for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      end
      drive(1'b1, 56'h6100, 64'hD0, 8'hF0, 1'b0, 1'b0);
      drive(1'b1, 56'h6108, 64'hD1, 8'h0F, 1'b0, 1'b0);
      check("cq_full", bus.commit_ready_o, 0);
      man_gnt = 1; idle(1); man_gnt = 0;
      man_ack = 1; idle(1); man_ack = 0;
      check("cq_after_ack", bus.commit_ready_o, 1);
      man_gnt = 1; idle(1); man_gnt = 0;
      man_ack = 1; drive(1'b0, '0, '0, '0, 1'b1, 1'b0); man_ack = 0;
      check("cq_ack_and_commit", bus.commit_ready_o, 1);
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      check("cq_full_again", bus.commit_ready_o, 0);
      auto_resp = 1'b1;
      drain(100, "drain_full");

      // Overlap detection against a store parked in the commit queue.
      auto_resp = 1'b0;
      drive(1'b1, 56'h2A48, 64'h77, 8'hFF, 1'b0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      bus.fwd_offset_i = 12'hA4C;
      #1 check("fwd_hit", bus.fwd_match_o, fwd_on);
      bus.fwd_offset_i = 12'hA50;
      #1 check("fwd_miss", bus.fwd_match_o, 0);
      auto_resp = 1'b1;
      drain(30, "drain_fwd");

      // Random traffic.
      gnt_pct = 60; ack_pct = 50;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         bit v, c, f;
         a = {24'($urandom), 32'h1000 + 32'($urandom_range(31)) * 32'd8};
         v = ($urandom_range(99) < 55);
         c = (spec_q.size() != 0) && (cq.size() != CD) && ($urandom_range(99) < 40);
         f = ($urandom_range(99) < 3);
         bus.fwd_offset_i = 12'(32'h000 + $urandom_range(40) * 8 + $urandom_range(7));
         drive(v, a, {$urandom, $urandom},
               ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom), c, f);
      end
      drain(300, "drain_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
